// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with bubble insertion, hold and EX-stage forwarding.
// Drives the ALU operand/control inputs directly from registered ID state.
module id_ex_stage #(
    parameter int DW = 32,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          id_valid,
    input  logic [DW-1:0] id_pc,
    input  logic [DW-1:0] id_rs_val,
    input  logic [DW-1:0] id_rt_val,
    input  logic [DW-1:0] id_imm,
    input  logic [4:0]    id_rs_addr,
    input  logic [4:0]    id_rt_addr,
    input  logic [4:0]    id_dst_addr,
    input  logic [2:0]    id_alu_ctrl,
    input  logic          id_alusrc,
    input  logic          id_reg_we,
    input  logic          id_stall,
    input  logic          ex_flush,
    input  logic          ex_hold,
    input  logic          mem_fwd_we,
    input  logic [4:0]    mem_fwd_addr,
    input  logic [DW-1:0] mem_fwd_data,
    input  logic          wb_fwd_we,
    input  logic [4:0]    wb_fwd_addr,
    input  logic [DW-1:0] wb_fwd_data,
    output logic [DW-1:0] alu_op1,
    output logic [DW-1:0] alu_op2,
    output logic [2:0]    alu_ctrl,
    output logic          ex_valid,
    output logic [DW-1:0] ex_pc,
    output logic [DW-1:0] ex_store_data,
    output logic [4:0]    ex_dst_addr,
    output logic          ex_reg_we,
    output logic [CW-1:0] bubble_cnt
);

    logic          v_q;
    logic [DW-1:0] pc_q;
    logic [DW-1:0] rs_q;
    logic [DW-1:0] rt_q;
    logic [DW-1:0] imm_q;
    logic [4:0]    rsa_q;
    logic [4:0]    rta_q;
    logic [4:0]    dst_q;
    logic [2:0]    ctrl_q;
    logic          src_q;
    logic          we_q;
    logic [CW-1:0] cnt_q;

    logic          bub;
    logic          cap;
    logic [DW-1:0] rs_fwd;
    logic [DW-1:0] rt_fwd;

    // Flush beats hold; hold beats stall/empty.
    assign bub = ex_flush | (~ex_hold & (id_stall | ~id_valid));
    assign cap = ~ex_flush & ~ex_hold & ~id_stall & id_valid;

    always_ff @(posedge clk) begin
        if (!rst_n || bub) begin
            v_q    <= 1'b0;
            pc_q   <= '0;
            rs_q   <= '0;
            rt_q   <= '0;
            imm_q  <= '0;
            rsa_q  <= '0;
            rta_q  <= '0;
            dst_q  <= '0;
            ctrl_q <= '0;
            src_q  <= 1'b0;
            we_q   <= 1'b0;
        end else if (cap) begin
            v_q    <= 1'b1;
            pc_q   <= id_pc;
            rs_q   <= id_rs_val;
            rt_q   <= id_rt_val;
            imm_q  <= id_imm;
            rsa_q  <= id_rs_addr;
            rta_q  <= id_rt_addr;
            dst_q  <= id_dst_addr;
            ctrl_q <= id_alu_ctrl;
            src_q  <= id_alusrc;
            we_q   <= id_reg_we;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (bub && cnt_q != {CW{1'b1}}) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Youngest producer (EX/MEM) wins; $0 is never forwarded.
    always_comb begin
        rs_fwd = rs_q;
        if (mem_fwd_we && mem_fwd_addr == rsa_q && rsa_q != 5'd0) begin
            rs_fwd = mem_fwd_data;
        end else if (wb_fwd_we && wb_fwd_addr == rsa_q && rsa_q != 5'd0) begin
            rs_fwd = wb_fwd_data;
        end
    end

    always_comb begin
        rt_fwd = rt_q;
        if (mem_fwd_we && mem_fwd_addr == rta_q && rta_q != 5'd0) begin
            rt_fwd = mem_fwd_data;
        end else if (wb_fwd_we && wb_fwd_addr == rta_q && rta_q != 5'd0) begin
            rt_fwd = wb_fwd_data;
        end
    end

    assign alu_op1       = rs_fwd;
    assign alu_op2       = src_q ? imm_q : rt_fwd;
    assign alu_ctrl      = ctrl_q;
    assign ex_valid      = v_q;
    assign ex_pc         = pc_q;
    assign ex_store_data = rt_fwd;
    assign ex_dst_addr   = dst_q;
    assign ex_reg_we     = we_q & v_q;
    assign bubble_cnt    = cnt_q;

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register and EX-stage operand selector of the 5-stage MIPS core.
- Captures decoded operands and controls from ID, inserts bubbles on stall/flush, and holds on downstream back-pressure.
- Resolves RAW hazards by forwarding from EX/MEM and MEM/WB.
- Drives op1/op2/ALUCtrl of the EX-stage ALU directly.

Parameters:
- DW, 32, datapath width (operands, PC, immediate).
- CW, 16, width of the saturating bubble counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous reset, active low.
- id_valid  in  1  ID holds a real instruction.
- id_pc  in  DW  PC of the ID instruction.
- id_rs_val  in  DW  GPR[rs] read in ID (regfile is write-through).
- id_rt_val  in  DW  GPR[rt] read in ID.
- id_imm  in  DW  extended immediate.
- id_rs_addr  in  5  rs index.
- id_rt_addr  in  5  rt index.
- id_dst_addr  in  5  destination register index.
- id_alu_ctrl  in  3  ALU op: 000 add, 001 sub, 010 or, 011 bit-reverse op1.
- id_alusrc  in  1  1 = op2 from immediate, 0 = from rt.
- id_reg_we  in  1  instruction writes GPR.
- id_stall  in  1  hazard unit: ID instruction must not advance; insert bubble.
- ex_flush  in  1  kill the instruction entering EX.
- ex_hold  in  1  downstream stall; EX contents must not change.
- mem_fwd_we  in  1  EX/MEM instruction writes GPR with a ready result.
- mem_fwd_addr  in  5  EX/MEM destination.
- mem_fwd_data  in  DW  EX/MEM result.
- wb_fwd_we  in  1  MEM/WB write enable.
- wb_fwd_addr  in  5  MEM/WB destination.
- wb_fwd_data  in  DW  MEM/WB write data.
- alu_op1  out  DW  to ALU op1.
- alu_op2  out  DW  to ALU op2.
- alu_ctrl  out  3  to ALU ALUCtrl.
- ex_valid  out  1  EX holds a real instruction.
- ex_pc  out  DW  PC of the EX instruction.
- ex_store_data  out  DW  forwarded rt value (for sw).
- ex_dst_addr  out  5  destination carried to EX/MEM.
- ex_reg_we  out  1  write enable carried to EX/MEM; forced 0 when !ex_valid.
- bubble_cnt  out  CW  count of bubble cycles inserted.

Behaviour:
- Register update priority at each rising edge:
  - 1. rst_n==0: all registers cleared. ex_valid=0, ex_reg_we=0, alu_ctrl reg=000, pc/rs/rt/imm=0, addrs=0, alusrc=0, bubble_cnt=0.
  - 2. ex_flush: load bubble (all fields as reset), bubble_cnt +1. ex_flush overrides ex_hold.
  - 3. ex_hold: all registers, including bubble_cnt, retain their values.
  - 4. id_stall or !id_valid: load bubble, bubble_cnt +1.
  - 5. Otherwise: capture all id_* fields, ex_valid=1.
- Latency: an ID instruction appears on the EX outputs 1 cycle after capture.
- bubble_cnt saturates at 2^CW-1 and never wraps.
- Forwarding is combinational on the registered rs/rt addresses. It is re-evaluated every cycle, including while held.
- Forwarded rs value:
  - Use mem_fwd_data if mem_fwd_we and mem_fwd_addr==rs_addr and rs_addr!=0.
  - Else use wb_fwd_data if wb_fwd_we and wb_fwd_addr==rs_addr and rs_addr!=0.
  - Else use the registered rs value.
- Forwarded rt value: same rule as rs.
- EX/MEM wins over MEM/WB when both match. Register 0 is never forwarded.
- alu_op1 = forwarded rs.
- alu_op2 = alusrc ? registered imm : forwarded rt.
- ex_store_data = forwarded rt, regardless of alusrc.
- alu_ctrl is the registered value.
- Bubble outputs: alu_op1=0, alu_op2=0, alu_ctrl=000 (0+0), ex_reg_we=0, ex_dst_addr=0. Forwarding muxes see address 0, so they are inactive.
- Load-use hazards are not detected here. The hazard unit asserts id_stall, and mem_fwd_we is low for loads in EX/MEM.
- No combinational path from id_* to any output.

Test Plan:
- Reset: rst_n=0 for 2 cycles with id_valid=1 and random id_* -> all outputs 0, alu_ctrl=000, bubble_cnt=0. Release -> first id instruction appears 1 cycle later.
- Pass-through: addiu (rs=$8 val 0x10, imm 0xFFFFFFFF, alusrc=1, ctrl 000, dst=$9) -> next cycle alu_op1=0x10, alu_op2=0xFFFFFFFF, ex_dst_addr=9, ex_reg_we=1.
- Forwarding priority:
  - rs=rt=$5, alusrc=0.
  - mem_fwd (we=1, addr 5, data 0xAAAA0000) and wb_fwd (we=1, addr 5, data 0x5555) both match.
  - Expect alu_op1=alu_op2=0xAAAA0000.
  - Drop mem_fwd_we -> both become 0x5555.
  - Set addr to 0 with rs=$0 -> registered value used.
- Stall/hold: id_stall=1 for 3 cycles -> 3 bubbles, bubble_cnt=3. Then ex_hold=1 for 2 cycles with new id data -> EX registers and bubble_cnt unchanged.
- Flush vs hold: ex_flush=1 and ex_hold=1 same edge -> bubble loaded, ex_valid=0, bubble_cnt increments.
- Saturation: CW=4, 20 consecutive bubbles -> bubble_cnt stops at 15.
